// File: rtl/io_wb_arbiter_pkg.sv
// io_wb_arbiter_pkg: shared state encoding and counter sizing for the IO Wishbone arbiter
package io_wb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;
  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction
endpackage

// File: rtl/io_wb_timeout.sv
// io_wb_timeout: counts stalled strobe cycles and fires on the last cycle before giving up
module io_wb_timeout
  import io_wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  input  logic clear,
  output logic fire
);
  localparam int CW = cnt_width(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign fire = busy & ~ack & ~clear & (cnt_q == CW'(TIMEOUT - 1));
  // count waiting cycles; any ack, release or fire restarts from zero
  always_comb cnt_d = (clear | ack | fire) ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/io_wb_arbiter.sv
// io_wb_arbiter: round-robin two-master Wishbone arbiter with bus-timeout error
module io_wb_arbiter
  import io_wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);
  arb_state_t state_q, state_d;
  logic last_q, last_d;
  logic g0, g1, fire;
  assign g0 = state_q == GNT0;
  assign g1 = state_q == GNT1;
  assign grant_o = {g1, g0};
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  assign s_we_o  = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
  assign s_sel_o = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
  assign s_adr_o = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
  assign s_dat_o = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
  assign m0_ack_o = s_ack_i & g0 & ~fire;
  assign m1_ack_o = s_ack_i & g1 & ~fire;
  assign m0_err_o = fire & g0;
  assign m1_err_o = fire & g1;
  assign m0_dat_o = g0 ? s_dat_i : '0;
  assign m1_dat_o = g1 ? s_dat_i : '0;
  io_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .busy (s_cyc_o & s_stb_o),
    .ack  (s_ack_i),
    .clear(~s_cyc_o),
    .fire (fire)
  );
  // grant selection: tie goes to the master that did not hold the bus last
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i & (~m1_cyc_i | last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    state_d = (~m0_cyc_i | fire) ? IDLE : GNT0;
      GNT1:    state_d = (~m1_cyc_i | fire) ? IDLE : GNT1;
      default: state_d = IDLE;
    endcase
  end
  // state and round-robin history registers
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    last_q  <= rst ? 1'b1 : last_d;
  end
endmodule

// File: tb/tb_io_wb_arbiter.sv
// tb_io_wb_arbiter: randomized directed bench with a register-file slave and round-robin reference model
module tb_io_wb_arbiter;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0] grant_o;
  io_wb_arbiter #(.TIMEOUT(TIMEOUT), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );
  logic [15:0] sysinfo = 16'h1234;
  logic stall = 1'b0;
  logic [31:0] regs [4];
  // slave: one registered ack per strobe, byte-masked writes, word 2 is read-only sysinfo
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ack_i <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      s_ack_i <= s_cyc_o & s_stb_o & ~s_ack_i & ~stall;
      if (s_cyc_o & s_stb_o & ~s_ack_i & ~stall & s_we_o & (s_adr_o[3:2] != 2'd2))
        for (int b = 0; b < 4; b++) if (s_sel_o[b]) regs[s_adr_o[3:2]][8*b+:8] <= s_dat_o[8*b+:8];
    end
  end
  always_comb s_dat_i = (s_adr_o[3:2] == 2'd2) ? {16'hB50C, sysinfo} : regs[s_adr_o[3:2]];
  logic [1:0] ack_v, err_v;
  logic [31:0] dat_v [2];
  assign ack_v = {m1_ack_o, m0_ack_o};
  assign err_v = {m1_err_o, m0_err_o};
  assign dat_v[0] = m0_dat_o;
  assign dat_v[1] = m1_dat_o;
  int checks = 0;
  int errors = 0;
  bit last;
  logic [31:0] mregs [4];
  bit req [2];
  bit we [2];
  logic [31:0] adr [2];
  logic [31:0] dat [2];
  logic [3:0] sel [2];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return (a[3:2] == 2'd2) ? {16'hB50C, sysinfo} : mregs[a[3:2]];
  endfunction
  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (a[3:2] != 2'd2) mregs[a[3:2]] = (mregs[a[3:2]] & ~m) | (d & m);
  endtask
  task automatic drive(input int i, input bit on);
    if (i == 0) begin
      m0_cyc_i = on; m0_stb_i = on; m0_we_i = on & we[0];
      m0_adr_i = on ? adr[0] : '0; m0_dat_i = on ? dat[0] : '0; m0_sel_i = on ? sel[0] : '0;
    end else begin
      m1_cyc_i = on; m1_stb_i = on; m1_we_i = on & we[1];
      m1_adr_i = on ? adr[1] : '0; m1_dat_i = on ? dat[1] : '0; m1_sel_i = on ? sel[1] : '0;
    end
  endtask
  task automatic run();
    bit done [2];
    bit seen;
    int first;
    logic [1:0] g, pg;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      done[i] = !req[i];
      if (req[i]) drive(i, 1'b1);
    end
    first = (req[0] && req[1]) ? (last ? 0 : 1) : (req[0] ? 0 : 1);
    #1 chk("lat_idle", s_cyc_o, 0);
    pg = 2'b00;
    seen = 1'b0;
    for (int c = 0; c < 40 && !(done[0] && done[1]); c++) begin
      @(negedge clk);
      g = grant_o;
      if (c == 0) chk("lat_grant", s_cyc_o, 1);
      if (g != 2'b00 && g != pg) begin
        if (!seen) chk("first_grant", g, (first == 0) ? 2'b01 : 2'b10);
        else chk("idle_gap", pg, 2'b00);
        seen = 1'b1;
        last = g[1];
      end
      chk("no_err", err_v, 2'b00);
      for (int i = 0; i < 2; i++) begin
        if (!g[i]) chk("ungranted_resp", {ack_v[i], err_v[i], dat_v[i]}, 0);
        if (ack_v[i]) begin
          chk("ack_owner", g[i], 1);
          if (!we[i]) chk("rdata", dat_v[i], model_rd(adr[i]));
          else model_wr(adr[i], dat[i], sel[i]);
          drive(i, 1'b0);
          done[i] = 1'b1;
        end
      end
      pg = g;
    end
    chk("xfer_done", {done[1], done[0]}, 2'b11);
  endtask
  initial begin
    int n;
    bit hit;
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; adr[i] = '0; dat[i] = '0; sel[i] = '0;
    end
    drive(0, 1'b0);
    drive(1, 1'b0);
    last = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", {s_cyc_o, s_stb_o, ack_v, err_v}, 0);
    rst = 1'b0;
    req[0] = 1; req[1] = 0; we[0] = 1; adr[0] = 32'h0; dat[0] = 32'h0000_0155; sel[0] = 4'b0111;
    run();
    we[0] = 0;
    run();
    chk("gpio_oe", mregs[0], 32'h155);
    req[1] = 1; we[0] = 1; adr[0] = 32'h4; dat[0] = 32'hCAFE_F00D; sel[0] = 4'hF;
    we[1] = 0; adr[1] = 32'h4;
    run();
    we[0] = 0; adr[0] = 32'hC; we[1] = 1; adr[1] = 32'hC; dat[1] = 32'h1357_9BDF; sel[1] = 4'b1001;
    run();
    req[0] = 0; we[1] = 0; adr[1] = 32'h8;
    run();
    stall = 1'b1;
    req[0] = 1; req[1] = 0; we[0] = 0; adr[0] = 32'h4;
    @(negedge clk);
    drive(0, 1'b1);
    n = 0;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (grant_o == 2'b01) n++;
      chk("to_noack", ack_v, 2'b00);
      if (m0_err_o) begin
        hit = 1'b1;
        chk("to_cycles", n, TIMEOUT);
      end
    end
    chk("to_seen", hit, 1);
    last = 1'b0;
    @(negedge clk);
    chk("to_grant", grant_o, 2'b00);
    chk("to_scyc", {s_cyc_o, err_v}, 0);
    drive(0, 1'b0);
    req[0] = 0; req[1] = 1; we[1] = 0; adr[1] = 32'h0;
    @(negedge clk);
    drive(1, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_grant", grant_o, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", grant_o, 2'b00);
    chk("mid_rst_out", {s_cyc_o, s_stb_o, ack_v, err_v}, 0);
    drive(1, 1'b0);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    req[0] = 1; req[1] = 1; we[0] = 0; we[1] = 0; adr[0] = 32'h8; adr[1] = 32'h0;
    run();
    for (int k = 0; k < 25; k++) begin
      n = int'($urandom_range(1, 3));
      req[0] = n[0];
      req[1] = n[1];
      for (int i = 0; i < 2; i++) begin
        we[i] = 1'($urandom_range(0, 1));
        adr[i] = 32'($urandom_range(0, 3)) << 2;
        dat[i] = $urandom;
        sel[i] = 4'($urandom_range(0, 15));
      end
      run();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
